// File: rtl/param_shift_reg_if.sv
// Control and observation bundle for param_shift_reg. The master drives the
// operation controls and the slave (the register) drives the state outputs.
interface param_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             sclr;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic [CNT_W-1:0] shift_cnt;
  logic             drained;

  modport master (
    output sclr, en, mode, d, sin,
    input  q, sout_msb, sout_lsb, shift_cnt, drained
  );

  modport slave (
    input  sclr, en, mode, d, sin,
    output q, sout_msb, sout_lsb, shift_cnt, drained
  );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate and arithmetic shift,
// with a saturating count of shifts since the last load or clear.
module param_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  param_shift_reg_if.slave bus
);
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             is_shift;

  always_comb begin
    q_nxt    = q_r;
    cnt_nxt  = cnt_r;
    is_shift = 1'b0;
    if (bus.sclr) begin
      q_nxt   = '0;
      cnt_nxt = '0;
    end else if (bus.en) begin
      case (bus.mode)
        M_HOLD: q_nxt = q_r;
        M_LOAD: begin
          q_nxt   = bus.d;
          cnt_nxt = '0;
        end
        M_SHL: begin
          q_nxt    = {q_r[WIDTH-2:0], bus.sin};
          is_shift = 1'b1;
        end
        M_SHR: begin
          q_nxt    = {bus.sin, q_r[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        M_ROL: begin
          q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          is_shift = 1'b1;
        end
        M_ROR: begin
          q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        M_ASR: begin
          q_nxt    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        default: q_nxt = q_r;
      endcase
      // The count sticks at WIDTH; the data path keeps shifting regardless.
      if (is_shift && (cnt_r != CNT_MAX)) begin
        cnt_nxt = cnt_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r   <= RESET_VAL;
      cnt_r <= '0;
    end else begin
      q_r   <= q_nxt;
      cnt_r <= cnt_nxt;
    end
  end

  assign bus.q         = q_r;
  assign bus.sout_msb  = q_r[WIDTH-1];
  assign bus.sout_lsb  = q_r[0];
  assign bus.shift_cnt = cnt_r;
  assign bus.drained   = (cnt_r == CNT_MAX);
endmodule
